// File: rtl/sha_state_regfile_if.sv
// Command/status bundle for the SHA-256 working-variable register file.
// master = round/compression controller, slave = the register file.
interface sha_state_regfile_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4,
  parameter int ROUNDS = 64
);
  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic                   en;
  logic [2:0]             op;
  logic [ADDR_W-1:0]      addr;
  logic [WIDTH-1:0]       in_var;
  logic [DEPTH*WIDTH-1:0] in_bus;
  logic [DEPTH*WIDTH-1:0] out_bus;
  logic [WIDTH-1:0]       rd_data;
  logic [RND_W-1:0]       round;
  logic                   round_last;
  logic                   addr_err;
  logic                   done;

  modport master (
    output en, op, addr, in_var, in_bus,
    input  out_bus, rd_data, round, round_last, addr_err, done
  );

  modport slave (
    input  en, op, addr, in_var, in_bus,
    output out_bus, rd_data, round, round_last, addr_err, done
  );
endinterface

// File: rtl/sha_state_regfile.sv
// SHA-256 working-variable register file (A..H): addressed write, bulk load,
// IV init, round shift, feed-forward add, round counter and registered read.
module sha_state_regfile #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4,
  parameter int ROUNDS = 64,
  parameter logic [DEPTH*WIDTH-1:0] INIT_VAL =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667
) (
  input logic             clk,
  input logic             rst_n,
  sha_state_regfile_if.slave bus
);
  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_INIT  = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ADD   = 3'd5;

  logic [DEPTH-1:0][WIDTH-1:0] word_q, word_d, in_w, init_w;
  logic [WIDTH-1:0]            rd_q, rd_sel;
  logic [RND_W-1:0]            round_q;
  logic                        done_q, aerr_q;
  logic                        addr_ok, op_valid, rnd_wrap;

  assign in_w   = bus.in_bus;
  assign init_w = INIT_VAL;

  // addr is 1-based so that 0 can act as a "no word" selector
  assign addr_ok  = (bus.addr != '0) && (bus.addr <= ADDR_W'(DEPTH));
  assign op_valid = (bus.op >= OP_WRITE) && (bus.op <= OP_ADD);
  assign rnd_wrap = (round_q == RND_W'(ROUNDS - 1));

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [WIDTH-1:0] prev, nxt;
    if (i == 0) begin : g_head
      assign prev = bus.in_var;
    end else begin : g_tail
      assign prev = word_q[i-1];
    end

    always_comb begin
      nxt = word_q[i];
      if (bus.en) begin
        case (bus.op)
          OP_WRITE: if (bus.addr == ADDR_W'(i + 1)) nxt = bus.in_var;
          OP_LOAD:  nxt = in_w[i];
          OP_INIT:  nxt = init_w[i];
          OP_SHIFT: nxt = prev;
          OP_ADD:   nxt = word_q[i] + in_w[i];
          default:  nxt = word_q[i];
        endcase
      end
    end

    assign word_d[i] = nxt;
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.addr == ADDR_W'(i + 1)) rd_sel = word_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      rd_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      // read port samples pre-update contents and ignores en
      rd_q   <= rd_sel;
      done_q <= bus.en && op_valid;
      aerr_q <= bus.en && (bus.op == OP_WRITE) && !addr_ok;
      if (bus.en) begin
        case (bus.op)
          OP_LOAD, OP_INIT: round_q <= '0;
          OP_SHIFT:         round_q <= rnd_wrap ? '0 : round_q + 1'b1;
          default:          round_q <= round_q;
        endcase
      end
    end
  end

  assign bus.out_bus    = word_q;
  assign bus.rd_data    = rd_q;
  assign bus.round      = round_q;
  assign bus.round_last = rnd_wrap;
  assign bus.done       = done_q;
  assign bus.addr_err   = aerr_q;
endmodule

// File: tb/tb_sha_state_regfile.sv
// Directed bench for sha_state_regfile with hand-computed expectations.
module tb_sha_state_regfile;
  localparam int WIDTH = 32, DEPTH = 8, ADDR_W = 4, ROUNDS = 64;
  localparam logic [255:0] IV =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_aerr = 0;
  logic [255:0] exp_bus;

  sha_state_regfile_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ROUNDS(ROUNDS)) bus ();

  sha_state_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] setw(input logic [255:0] v, input int i, input logic [31:0] w);
    logic [255:0] r;
    r = v;
    r[i*32 +: 32] = w;
    return r;
  endfunction

  task automatic drive(input logic e, input logic [2:0] o, input logic [3:0] a,
                       input logic [31:0] v, input logic [255:0] b);
    bus.en = e; bus.op = o; bus.addr = a; bus.in_var = v; bus.in_bus = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) n_done++;
    if (bus.addr_err === 1'b1) n_aerr++;
  endtask

  initial begin
    drive(1'b0, 3'd0, 4'd0, 32'h0, 256'h0);

    // reset state
    #12;
    chk("rst_out_bus", bus.out_bus, 256'h0);
    chk("rst_rd_data", bus.rd_data, 32'h0);
    chk("rst_round", bus.round, 6'd0);
    chk("rst_round_last", bus.round_last, 1'b0);
    chk("rst_flags", {bus.done, bus.addr_err}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // INIT
    drive(1'b1, 3'd3, 4'd1, 32'h0, 256'h0);
    step();
    chk("init_out_bus", bus.out_bus, IV);
    chk("init_done", bus.done, 1'b1);
    chk("init_round", bus.round, 6'd0);
    chk("init_rd_pre", bus.rd_data, 32'h0);
    drive(1'b0, 3'd0, 4'd1, 32'h0, 256'h0);
    step();
    chk("init_rd_word0", bus.rd_data, 32'h6a09e667);
    chk("idle_done", bus.done, 1'b0);

    // WRITE valid then two invalid addresses
    n_done = 0; n_aerr = 0;
    drive(1'b1, 3'd1, 4'd3, 32'hdeadbeef, 256'h0);
    step();
    chk("wr3_rd_old", bus.rd_data, 32'h3c6ef372);
    chk("wr3_aerr", bus.addr_err, 1'b0);
    exp_bus = setw(IV, 2, 32'hdeadbeef);
    drive(1'b1, 3'd1, 4'd0, 32'h11111111, 256'h0);
    step();
    chk("wr0_aerr", bus.addr_err, 1'b1);
    chk("wr0_rd_zero", bus.rd_data, 32'h0);
    drive(1'b1, 3'd1, 4'd9, 32'h22222222, 256'h0);
    step();
    chk("wr9_aerr", bus.addr_err, 1'b1);
    chk("wr9_rd_zero", bus.rd_data, 32'h0);
    drive(1'b0, 3'd0, 4'd3, 32'h0, 256'h0);
    step();
    chk("wr_out_bus", bus.out_bus, exp_bus);
    chk("wr_aerr_count", n_aerr, 2);
    chk("wr_done_count", n_done, 3);
    chk("wr_rd_word2", bus.rd_data, 32'hdeadbeef);

    // reserved op behaves as NOP
    drive(1'b1, 3'd6, 4'd1, 32'h33333333, 256'h0);
    step();
    chk("rsv_done", bus.done, 1'b0);
    chk("rsv_out_bus", bus.out_bus, exp_bus);

    // LOAD_ALL 1..8 then SHIFT
    drive(1'b1, 3'd2, 4'd0, 32'h0,
          256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    step();
    chk("load_out_bus", bus.out_bus,
        256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    chk("load_round", bus.round, 6'd0);
    drive(1'b1, 3'd4, 4'd0, 32'hAAAAAAAA, 256'h0);
    step();
    chk("shift_out_bus", bus.out_bus,
        256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_AAAAAAAA);
    chk("shift_round", bus.round, 6'd1);

    // ADD_ALL with carry drop; round must survive
    drive(1'b1, 3'd2, 4'd0, 32'h0, {8{32'hffffffff}});
    step();
    drive(1'b1, 3'd4, 4'd0, 32'hffffffff, 256'h0);
    step();
    chk("pre_add_round", bus.round, 6'd1);
    drive(1'b1, 3'd5, 4'd0, 32'h0, {8{32'h00000002}});
    step();
    chk("add_out_bus", bus.out_bus, {8{32'h00000001}});
    chk("add_round", bus.round, 6'd1);
    chk("add_done", bus.done, 1'b1);

    // 64 SHIFTs after INIT: round_last and wrap
    drive(1'b1, 3'd3, 4'd0, 32'h0, 256'h0);
    step();
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, 3'd4, 4'd0, 32'h10000000 + k, 256'h0);
      step();
      if (k == 61) chk("rnd62_last", bus.round_last, 1'b0);
      if (k == 62) begin
        chk("rnd63_round", bus.round, 6'd63);
        chk("rnd63_last", bus.round_last, 1'b1);
      end
    end
    chk("wrap_round", bus.round, 6'd0);
    chk("wrap_last", bus.round_last, 1'b0);
    exp_bus = '0;
    for (int j = 0; j < 8; j++) exp_bus = setw(exp_bus, j, 32'h10000000 + 63 - j);
    chk("wrap_out_bus", bus.out_bus, exp_bus);

    // async reset in the middle of a SHIFT burst
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd4, 4'd0, 32'h50000000 + k, 256'h0);
      step();
    end
    chk("burst_round", bus.round, 6'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_bus", bus.out_bus, 256'h0);
    chk("arst_round", bus.round, 6'd0);
    chk("arst_flags", {bus.done, bus.addr_err}, 2'b00);
    step();
    chk("arst_hold_out_bus", bus.out_bus, 256'h0);
    chk("arst_hold_round", bus.round, 6'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 3'd4, 4'd1, 32'h77777777, 256'h0);
    step();
    chk("post_rst_round", bus.round, 6'd1);
    chk("post_rst_out_bus", bus.out_bus, 256'h77777777);
    chk("post_rst_rd", bus.rd_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
